alu_stage: RTL and testbench



---
 rtl/risc_pkg.sv | 18 +
 rtl/alu_core.sv | 40 ++++
 rtl/alu_stage.sv | 75 +++++++
 tb/tb_alu_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared datapath definitions for the RISC ALU stage: op encoding,
// status bit positions and the default datapath width.
package risc_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    localparam int STAT_Z = 2;
    localparam int STAT_N = 1;
    localparam int STAT_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD/SUB/AND/NOT-B with zero, negative and signed
// overflow flags derived from the result.
module alu_core
    import risc_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  alu_op_e          alu_op,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v
);

    localparam int MSB = WIDTH - 1;

    always_comb begin
        result = '0;
        v      = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = ain + bin;
                v      = (ain[MSB] == bin[MSB]) && (result[MSB] != ain[MSB]);
            end
            ALU_SUB: begin
                result = ain - bin;
                v      = (ain[MSB] != bin[MSB]) && (result[MSB] != ain[MSB]);
            end
            ALU_AND: result = ain & bin;
            ALU_NOT: result = ~bin;
            default: result = '0;
        endcase
    end

    assign z = (result == '0);
    assign n = result[MSB];

endmodule

// File: rtl/alu_stage.sv
// Registered ALU stage behind the barrel shifter: operand muxes, a
// valid/ready handshake, and the C result and {Z,N,V} status registers.
module alu_stage
    import risc_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] sout,
    input  logic [WIDTH-1:0] sximm5,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       alu_op,
    input  logic             loads,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       status
);

    logic [WIDTH-1:0] ain_sel;
    logic [WIDTH-1:0] bin_sel;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             v;
    logic [2:0]       flags;
    logic             accept;

    assign ain_sel = asel ? '0 : ain;
    assign bin_sel = bsel ? sximm5 : sout;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .ain    (ain_sel),
        .bin    (bin_sel),
        .alu_op (alu_op_e'(alu_op)),
        .result (result),
        .z      (z),
        .n      (n),
        .v      (v)
    );

    always_comb begin
        flags         = '0;
        flags[STAT_Z] = z;
        flags[STAT_N] = n;
        flags[STAT_V] = v;
    end

    // Ready depends only on the output side so upstream never sees a
    // combinational loop through in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c         <= '0;
            status    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            c         <= result;
            out_valid <= 1'b1;
            if (loads) begin
                status <= flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: reset, arithmetic/flag cases, back-pressure,
// streaming and asynchronous reset with a held result.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ain;
    logic [15:0] sout;
    logic [15:0] sximm5;
    logic        asel;
    logic        bsel;
    logic [1:0]  alu_op;
    logic        loads;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
    logic [2:0]  status;

    int n_chk  = 0;
    int n_pass = 0;

    alu_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .sout      (sout),
        .sximm5    (sximm5),
        .asel      (asel),
        .bsel      (bsel),
        .alu_op    (alu_op),
        .loads     (loads),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] s, input logic [15:0] imm,
                         input logic as, input logic bs, input logic [1:0] op, input logic ld);
        in_valid = 1'b1;
        ain      = a;
        sout     = s;
        sximm5   = imm;
        asel     = as;
        bsel     = bs;
        alu_op   = op;
        loads    = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // streaming vectors: ain, sout, expected c, expected status
    logic [15:0] st_a   [4] = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [15:0] st_b   [4] = '{16'h0002, 16'h0001, 16'h0001, 16'h8000};
    logic [15:0] st_c   [4] = '{16'h0003, 16'h8000, 16'h0000, 16'h0000};
    logic [2:0]  st_s   [4] = '{3'b000,   3'b011,   3'b100,   3'b101};

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        ain       = '0;
        sout      = '0;
        sximm5    = '0;
        asel      = 1'b0;
        bsel      = 1'b0;
        alu_op    = 2'b00;
        loads     = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("rst_c", c, 16'h0000);
        chk("rst_status", {13'd0, status}, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);

        // ADD wrapping to zero
        step();
        drive(16'h1E62, 16'hE19E, 16'h5555, 1'b0, 1'b0, 2'b00, 1'b1);
        step();
        chk("add_c", c, 16'h0000);
        chk("add_status", {13'd0, status}, 16'h0004);
        chk("add_out_valid", {15'd0, out_valid}, 16'h0001);

        // SUB with signed overflow through the immediate path
        drive(16'h8000, 16'h1234, 16'h0001, 1'b0, 1'b1, 2'b01, 1'b1);
        step();
        chk("sub_c", c, 16'h7FFF);
        chk("sub_status", {13'd0, status}, 16'h0001);

        // NOT with Ain forced to zero, status held
        drive(16'hABCD, 16'h1111, 16'hFFF0, 1'b1, 1'b1, 2'b11, 1'b0);
        step();
        chk("not_c", c, 16'h000F);
        chk("not_status", {13'd0, status}, 16'h0001);

        // back-pressure
        out_ready = 1'b0;
        drive(16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 2'b10, 1'b1);
        #1;
        chk("bp_in_ready", {15'd0, in_ready}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_in_ready", {15'd0, in_ready}, 16'h0000);
            chk("bp_hold_c", c, 16'h000F);
            chk("bp_hold_out_valid", {15'd0, out_valid}, 16'h0001);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {15'd0, in_ready}, 16'h0001);
        step();
        chk("and_c", c, 16'h00F0);
        chk("and_out_valid", {15'd0, out_valid}, 16'h0001);
        chk("and_status", {13'd0, status}, 16'h0000);

        // streaming ADDs
        for (int i = 0; i < 4; i++) begin
            drive(st_a[i], st_b[i], 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1);
            chk("stream_in_ready", {15'd0, in_ready}, 16'h0001);
            step();
            chk("stream_c", c, st_c[i]);
            chk("stream_status", {13'd0, status}, {13'd0, st_s[i]});
            chk("stream_out_valid", {15'd0, out_valid}, 16'h0001);
        end
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("drain_c_hold", c, 16'h0000);
        chk("drain_status_hold", {13'd0, status}, 16'h0005);

        // held result, then async reset mid-cycle
        out_ready = 1'b0;
        drive(16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        in_valid = 1'b0;
        chk("pre_rst_c", c, 16'h0003);
        chk("pre_rst_out_valid", {15'd0, out_valid}, 16'h0001);
        chk("pre_rst_status", {13'd0, status}, 16'h0005);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_c", c, 16'h0000);
        chk("mid_rst_status", {13'd0, status}, 16'h0000);
        chk("mid_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("mid_rst_in_ready", {15'd0, in_ready}, 16'h0001);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_out_valid", {15'd0, out_valid}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
